instr_mem_sync: RTL

Parametrised, synchronous instruction memory for the 16-bit MIPS datapath. It replaces a hard-coded combinational program table with a loadable RAM. The fetch side uses a valid/ready request/response handshake with 1-cycle read latency. A program-load write port lets the bench or boot logic write the program. Reset runs a self-clear sequence that fills every word with NOP before fetches are accepted.

---
 rtl/instr_mem_sync.sv | 101 ++++++++++
 1 files changed

// File: rtl/instr_mem_sync.sv
// Loadable synchronous instruction memory for the 16-bit MIPS datapath.
// Reset self-clears every word to NOP, then serves 1-cycle-latency fetches.
module instr_mem_sync #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              Busy,
    input  logic              LoadEn,
    input  logic [ADDR_W-1:0] LoadAddr,
    input  logic [DATA_W-1:0] LoadData,
    output logic              LoadFault,
    input  logic              FetchValid,
    output logic              FetchReady,
    input  logic [ADDR_W-1:0] FetchAddr,
    output logic              InstrValid,
    input  logic              InstrReady,
    output logic [DATA_W-1:0] Instruction,
    output logic              AddrFault
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              run;
    logic              fetch_acc_p0;
    logic              load_ok_p0;
    logic              clr_we_p0;
    logic [IDX_W-1:0]  load_idx_p0;
    logic [IDX_W-1:0]  fetch_idx_p0;
    logic [DATA_W-1:0] fetch_word_p0;

    // Range check on the full address width so high bits never alias low words.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_X;
    endfunction

    assign run          = (state == RUN);
    assign Busy         = !run;
    assign FetchReady   = run && (!InstrValid || InstrReady);
    assign fetch_acc_p0 = FetchValid && FetchReady && !rst;
    assign load_ok_p0   = !rst && run && LoadEn && in_range(LoadAddr);
    assign clr_we_p0    = !rst && !run;
    assign load_idx_p0  = LoadAddr[IDX_W-1:0];
    assign fetch_idx_p0 = FetchAddr[IDX_W-1:0];

    // Write-first: a same-cycle load to the fetched word forwards its data.
    always_comb begin
        fetch_word_p0 = NOP_WORD;
        if (in_range(FetchAddr)) begin
            if (load_ok_p0 && (LoadAddr == FetchAddr))
                fetch_word_p0 = LoadData;
            else
                fetch_word_p0 = mem[fetch_idx_p0];
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we_p0)
            mem[ptr] <= NOP_WORD;
        else if (load_ok_p0)
            mem[load_idx_p0] <= LoadData;
    end

    // p0 -> p1: registered response, clear sequencer and load-fault pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CLEAR;
            ptr         <= '0;
            InstrValid  <= 1'b0;
            Instruction <= NOP_WORD;
            AddrFault   <= 1'b0;
            LoadFault   <= 1'b0;
        end else begin
            LoadFault <= LoadEn && (!run || !in_range(LoadAddr));
            if (!run) begin
                ptr <= ptr + 1'b1;
                if (ptr == LAST)
                    state <= RUN;
            end
            if (fetch_acc_p0) begin
                InstrValid  <= 1'b1;
                Instruction <= fetch_word_p0;
                AddrFault   <= !in_range(FetchAddr);
            end else if (InstrReady) begin
                InstrValid <= 1'b0;
            end
        end
    end

endmodule
